// File: rtl/sd_sector_arbiter.sv
// Shares the user_io SD sector interface between two clients, one 512-byte sector per grant.
// The SPI-domain ack and byte strobes are synchronized into clk; reads stream out, writes fetch on demand.
module sd_sector_arbiter #(
  parameter bit          SDHC    = 1'b1,
  parameter logic [23:0] TIMEOUT = 24'd8000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cl_rd,
  input  logic [1:0]  cl_wr,
  input  logic [31:0] cl_lba0,
  input  logic [31:0] cl_lba1,
  input  logic [7:0]  cl_din0,
  input  logic [7:0]  cl_din1,
  output logic [1:0]  cl_grant,
  output logic [1:0]  cl_done,
  output logic        cl_err,
  output logic [7:0]  cl_dout,
  output logic [1:0]  cl_dout_valid,
  output logic [1:0]  cl_din_req,
  output logic [8:0]  cl_byte_idx,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        sd_conf,
  output logic        sd_sdhc,
  input  logic        sd_ack,
  input  logic [7:0]  sd_dout,
  input  logic        sd_dout_strobe,
  output logic [7:0]  sd_din,
  input  logic        sd_din_strobe,
  output logic [2:0]  dbg_state
);

  // Handshake: a client holds cl_rd/cl_wr as a level until its cl_done pulse; data moves as
  // single-cycle pulses (cl_dout_valid, cl_din_req) with no back-pressure, and the client must
  // present cl_din for cl_byte_idx on the cycle cl_din_req is high.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  ack_sr;
  logic [2:0]  dstb_sr, istb_sr;
  logic        ack_s, dstb_e, istb_e;
  logic [9:0]  cnt;
  logic [23:0] timer;
  logic        dir, rr_last, fetch_pend;
  logic        pend0, pend1, start, sel, sel_wr, timed_out, cnt_full;
  logic [7:0]  din_g;

  assign sd_conf   = 1'b0;
  assign sd_sdhc   = SDHC;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_sr  <= '0;
      dstb_sr <= '0;
      istb_sr <= '0;
    end else begin
      ack_sr  <= {ack_sr[0], sd_ack};
      dstb_sr <= {dstb_sr[1:0], sd_dout_strobe};
      istb_sr <= {istb_sr[1:0], sd_din_strobe};
    end
  end

  assign ack_s  = ack_sr[1];
  assign dstb_e = dstb_sr[1] & ~dstb_sr[2];
  assign istb_e = istb_sr[1] & ~istb_sr[2];

  assign pend0     = cl_rd[0] | cl_wr[0];
  assign pend1     = cl_rd[1] | cl_wr[1];
  assign start     = pend0 | pend1;
  assign timed_out = (TIMEOUT != 24'd0) && (timer == TIMEOUT);
  assign cnt_full  = (cnt == 10'd512);
  assign din_g     = cl_grant[1] ? cl_din1 : cl_din0;

  always_comb begin
    sel    = 1'b0;
    sel_wr = 1'b0;
    if (pend0 && pend1) sel = ~rr_last;
    else                sel = pend1;
    // A client asserting both read and write is served as a read.
    if (sel) sel_wr = cl_wr[1] & ~cl_rd[1];
    else     sel_wr = cl_wr[0] & ~cl_rd[0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ: begin
        if (ack_s)          state_nxt = S_XFER;
        else if (timed_out) state_nxt = S_DONE;
      end
      S_XFER: begin
        if (cnt_full)    state_nxt = S_DRAIN;
        else if (!ack_s) state_nxt = S_DONE;
      end
      S_DRAIN: if (!ack_s) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cl_grant      <= '0;
      cl_done       <= '0;
      cl_err        <= 1'b0;
      cl_dout       <= '0;
      cl_dout_valid <= '0;
      cl_din_req    <= '0;
      cl_byte_idx   <= '0;
      sd_lba        <= '0;
      sd_rd         <= 1'b0;
      sd_wr         <= 1'b0;
      sd_din        <= '0;
      cnt           <= '0;
      timer         <= '0;
      dir           <= 1'b0;
      rr_last       <= 1'b1;
      fetch_pend    <= 1'b0;
    end else begin
      cl_done       <= '0;
      cl_dout_valid <= '0;
      cl_din_req    <= '0;
      case (state)
        S_IDLE: begin
          cl_err <= 1'b0;
          if (start) begin
            sd_lba     <= sel ? cl_lba1 : cl_lba0;
            cl_grant   <= sel ? 2'b10 : 2'b01;
            dir        <= sel_wr;
            sd_rd      <= ~sel_wr;
            sd_wr      <= sel_wr;
            cnt        <= '0;
            timer      <= '0;
            fetch_pend <= 1'b0;
          end
        end
        S_REQ: begin
          timer <= timer + 24'd1;
          if (ack_s) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
          end else if (timed_out) begin
            sd_rd  <= 1'b0;
            sd_wr  <= 1'b0;
            cl_err <= 1'b1;
          end
        end
        S_XFER: begin
          if (!dir) begin
            if (dstb_e && !cnt_full) begin
              cl_dout       <= sd_dout;
              cl_dout_valid <= cl_grant;
              cl_byte_idx   <= cnt[8:0];
              cnt           <= cnt + 10'd1;
            end
          end else if (fetch_pend) begin
            // The client answered cl_din_req during the previous cycle.
            sd_din     <= din_g;
            cnt        <= cnt + 10'd1;
            fetch_pend <= 1'b0;
          end else if (istb_e && !cnt_full) begin
            cl_din_req  <= cl_grant;
            cl_byte_idx <= cnt[8:0];
            fetch_pend  <= 1'b1;
          end
        end
        S_DONE: begin
          cl_done  <= cl_grant;
          cl_grant <= '0;
          rr_last  <= cl_grant[1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Randomized bench for sd_sector_arbiter: an SD-host model drives ack/strobes, a scoreboard
// holds expected requests, bytes and completions, and a monitor compares DUT events against them.
module tb_sd_sector_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cl_rd, cl_wr;
  logic [31:0] cl_lba0, cl_lba1;
  logic [7:0]  cl_din0, cl_din1;
  logic [1:0]  cl_grant, cl_done, cl_dout_valid, cl_din_req;
  logic        cl_err;
  logic [7:0]  cl_dout;
  logic [8:0]  cl_byte_idx;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_conf, sd_sdhc, sd_ack;
  logic [7:0]  sd_dout, sd_din;
  logic        sd_dout_strobe, sd_din_strobe;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int m_rr_last = 1;

  logic [33:0] exp_req_q[$];   // {wr, client, lba}
  logic [17:0] exp_byte_q[$];  // {client, idx, data}
  logic [17:0] exp_din_q[$];   // {client, idx, byte the client supplies}
  logic [1:0]  exp_done_q[$];  // {client, err}

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    tests++;
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Clients answer a byte request from the index being asked for.
  assign cl_din0 = cl_byte_idx[7:0] ^ 8'hC3;
  assign cl_din1 = cl_byte_idx[7:0] ^ 8'h5A;

  sd_sector_arbiter #(.SDHC(1'b1), .TIMEOUT(24'd1000)) dut (
    .clk(clk), .reset(reset),
    .cl_rd(cl_rd), .cl_wr(cl_wr), .cl_lba0(cl_lba0), .cl_lba1(cl_lba1),
    .cl_din0(cl_din0), .cl_din1(cl_din1),
    .cl_grant(cl_grant), .cl_done(cl_done), .cl_err(cl_err), .cl_dout(cl_dout),
    .cl_dout_valid(cl_dout_valid), .cl_din_req(cl_din_req), .cl_byte_idx(cl_byte_idx),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_conf(sd_conf), .sd_sdhc(sd_sdhc),
    .sd_ack(sd_ack), .sd_dout(sd_dout), .sd_dout_strobe(sd_dout_strobe),
    .sd_din(sd_din), .sd_din_strobe(sd_din_strobe), .dbg_state(dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input logic [63:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cl_outs"}, {cl_grant, cl_done, cl_err, cl_dout, cl_dout_valid,
                              cl_din_req, cl_byte_idx}, 64'd0);
    check({tag, "_sd_outs"}, {sd_lba, sd_rd, sd_wr, sd_conf, sd_din}, 64'd0);
    check({tag, "_sdhc"}, sd_sdhc, 64'd1);
    check({tag, "_state_idle"}, dbg_state, 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic expect_sector(input int c, input bit wr, input logic [31:0] lba, input bit err);
    exp_req_q.push_back({wr, c[0], lba});
    exp_done_q.push_back({c[0], err});
    m_rr_last = c;
  endtask

  task automatic issue(input int c, input bit wr, input logic [31:0] lba, input bit err);
    if (c == 0) cl_lba0 = lba;
    else        cl_lba1 = lba;
    expect_sector(c, wr, lba, err);
    if (wr) cl_wr[c] = 1'b1;
    else    cl_rd[c] = 1'b1;
  endtask

  task automatic wait_req(input int bound);
    int n = 0;
    while (!(sd_rd || sd_wr) && n < bound) begin
      cyc(1);
      n++;
    end
    if (!(sd_rd || sd_wr)) report_fail("wait_req_timeout", n);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (cl_done == 2'b00 && n < bound) begin
      cyc(1);
      n++;
    end
    if (cl_done == 2'b00) report_fail("wait_done_timeout", n);
  endtask

  task automatic host_ack(input int ack_dly);
    wait_req(100);
    cyc(ack_dly);
    check("req_held_until_ack", sd_rd | sd_wr, 64'd1);
    sd_ack = 1'b1;
    cyc(4);
    check("req_released_after_ack", {sd_rd, sd_wr}, 64'd0);
  endtask

  // Sends n bytes; pat selects the 0x00..0xFF ramp, otherwise random data.
  task automatic host_read(input int c, input int n, input bit pat, input int ack_dly,
                           input int drop_at, input bit keep_ack);
    logic [7:0] d;
    host_ack(ack_dly);
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) begin
        cl_rd = 2'b00;
        cl_wr = 2'b00;
      end
      d = pat ? i[7:0] : 8'($urandom);
      sd_dout = d;
      exp_byte_q.push_back({c[0], i[8:0], d});
      sd_dout_strobe = 1'b1;
      cyc(2);
      sd_dout_strobe = 1'b0;
      cyc($urandom_range(2, 4));
    end
    cyc(4);
    if (!keep_ack) sd_ack = 1'b0;
  endtask

  task automatic host_write(input int c, input int n, input int ack_dly);
    logic [7:0] key;
    key = (c == 1) ? 8'h5A : 8'hC3;
    host_ack(ack_dly);
    for (int i = 0; i < n; i++) begin
      if (i < 512) exp_din_q.push_back({c[0], i[8:0], i[7:0] ^ key});
      sd_din_strobe = 1'b1;
      cyc(2);
      sd_din_strobe = 1'b0;
      cyc($urandom_range(3, 5));
    end
    cyc(4);
    sd_ack = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_req = 1'b0;
  logic        din_chk  = 1'b0;
  logic [7:0]  din_exp;
  logic [33:0] e_req;
  logic [17:0] e_b;
  logic [1:0]  e_d;

  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
      din_chk  = 1'b0;
    end else begin
      check("grant_onehot0", $onehot0(cl_grant), 64'd1);
      if ((sd_rd || sd_wr) && !prev_req) begin
        if (exp_req_q.size() == 0) report_fail("unexpected_request", {sd_wr, sd_rd});
        else begin
          e_req = exp_req_q.pop_front();
          check("req_dir", {sd_wr, sd_rd}, e_req[33] ? 64'd2 : 64'd1);
          check("req_grant", cl_grant, e_req[32] ? 64'd2 : 64'd1);
          check("req_lba", sd_lba, e_req[31:0]);
        end
      end
      prev_req = sd_rd || sd_wr;
      if (din_chk) begin
        check("sd_din", sd_din, din_exp);
        din_chk = 1'b0;
      end
      if (cl_dout_valid != 2'b00) begin
        if (exp_byte_q.size() == 0) report_fail("unexpected_dout_valid", cl_dout_valid);
        else begin
          e_b = exp_byte_q.pop_front();
          check("dout_valid_client", cl_dout_valid, e_b[17] ? 64'd2 : 64'd1);
          check("dout_idx", cl_byte_idx, e_b[16:8]);
          check("dout_data", cl_dout, e_b[7:0]);
        end
      end
      if (cl_din_req != 2'b00) begin
        if (exp_din_q.size() == 0) report_fail("unexpected_din_req", cl_din_req);
        else begin
          e_b = exp_din_q.pop_front();
          check("din_req_client", cl_din_req, e_b[17] ? 64'd2 : 64'd1);
          check("din_req_idx", cl_byte_idx, e_b[16:8]);
          din_exp = e_b[7:0];
          din_chk = 1'b1;
        end
      end
      if (cl_done != 2'b00) begin
        if (exp_done_q.size() == 0) report_fail("unexpected_done", cl_done);
        else begin
          e_d = exp_done_q.pop_front();
          check("done_client", cl_done, e_d[1] ? 64'd2 : 64'd1);
          check("done_err", cl_err, e_d[0]);
          check("done_grant_cleared", cl_grant, 64'd0);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int c;
    reset = 1'b1;
    cl_rd = '0;
    cl_wr = '0;
    cl_lba0 = '0;
    cl_lba1 = '0;
    sd_ack = 1'b0;
    sd_dout = '0;
    sd_dout_strobe = 1'b0;
    sd_din_strobe = 1'b0;
    cyc(3);
    check_reset_state("reset");
    reset = 1'b0;
    cyc(2);

    // Client 0 reads LBA 0x123 with a 0x00..0xFF ramp twice.
    issue(0, 1'b0, 32'h0000_0123, 1'b0);
    cyc(1);
    check("rd_latency_1cycle", sd_rd, 64'd1);
    host_read(0, 512, 1'b1, 50, -1, 1'b0);
    wait_done(50);
    cl_rd[0] = 1'b0;

    // Client 1 writes LBA 7; the 513th strobe must be ignored.
    cyc(3);
    issue(1, 1'b1, 32'd7, 1'b0);
    cyc(1);
    check("wr_latency_1cycle", sd_wr, 64'd1);
    host_write(1, 513, $urandom_range(10, 40));
    wait_done(50);
    cl_wr[1] = 1'b0;
    check("sd_din_holds_last", sd_din, 64'hA5);

    // Both clients hold reads; grants must alternate starting with client 0.
    cyc(3);
    cl_lba0 = $urandom;
    cl_lba1 = $urandom;
    for (int k = 0; k < 4; k++) begin
      c = (m_rr_last == 1) ? 0 : 1;
      expect_sector(c, 1'b0, (c == 1) ? cl_lba1 : cl_lba0, 1'b0);
      if (k == 0) cl_rd = 2'b11;
      host_read(c, $urandom_range(3, 12), 1'b0, $urandom_range(5, 20), -1, 1'b0);
      wait_done(50);
      if (k == 3) cl_rd = 2'b00;
    end

    // No ack: request must stay up exactly TIMEOUT+1 cycles, then done with error.
    cyc(3);
    issue(0, 1'b0, $urandom, 1'b1);
    wait_req(10);
    n = 0;
    while (sd_rd && n < 2000) begin
      n++;
      cyc(1);
    end
    check("timeout_req_cycles", n, 64'd1001);
    wait_done(20);
    cl_rd[0] = 1'b0;

    // The next request is served; the client drops its level mid-sector.
    cyc(2);
    issue(1, 1'b0, $urandom, 1'b0);
    host_read(1, 512, 1'b0, $urandom_range(5, 60), $urandom_range(1, 300), 1'b0);
    wait_done(50);

    // Reset at byte 200 of a read.
    cyc(3);
    issue(1, 1'b0, $urandom, 1'b0);
    host_read(1, 200, 1'b0, $urandom_range(5, 30), -1, 1'b1);
    cyc(4);
    reset = 1'b1;
    sd_ack = 1'b0;
    cl_rd = 2'b00;
    exp_done_q.delete();
    m_rr_last = 1;
    cyc(1);
    check_reset_state("midread_reset");
    reset = 1'b0;
    cyc(3);

    // Fresh read after reset completes cleanly.
    issue(0, 1'b0, $urandom, 1'b0);
    host_read(0, 512, 1'b0, $urandom_range(5, 60), -1, 1'b0);
    wait_done(50);
    cl_rd[0] = 1'b0;

    // Ack drops after 100 bytes: short sector, no error, no further bytes.
    cyc(3);
    issue(1, 1'b0, $urandom, 1'b0);
    host_read(1, 100, 1'b0, $urandom_range(5, 30), -1, 1'b0);
    wait_done(50);
    cl_rd[1] = 1'b0;
    cyc(40);

    check("req_q_empty", exp_req_q.size(), 64'd0);
    check("byte_q_empty", exp_byte_q.size(), 64'd0);
    check("din_q_empty", exp_din_q.size(), 64'd0);
    check("done_q_empty", exp_done_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
